rr_mux_nxw: RTL and testbench
=============================

RR_MUX_NXW -- requirements
Module: rr_mux_nxw

Interface
- REQ-001 Parameter N_CH, default 4: number of input channels; legal values are powers of two from 2 to 16.
- REQ-002 Parameter WIDTH, default 8: data bits per channel.
- REQ-003 Derived constant CH_W = $clog2(N_CH): channel index width.
- REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
- REQ-005 rst  input  1  reset, synchronous, active-high.
- REQ-006 mode  input  1  0 = direct select (MODE_DIRECT), 1 = round-robin (MODE_RR).
- REQ-007 sel  input  CH_W  channel index used in MODE_DIRECT; ignored in MODE_RR.
- REQ-008 in_data  input  N_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-009 in_valid  input  N_CH  per-channel data-valid flags.
- REQ-010 in_ready  output  N_CH  per-channel accept strobe; combinational.
- REQ-011 out_data  output  WIDTH  registered selected data.
- REQ-012 out_ch  output  CH_W  registered index of the channel that supplied out_data.
- REQ-013 out_valid  output  1  registered; out_data and out_ch hold a word.
- REQ-014 out_ready  input  1  downstream accept.

Function
- REQ-015 load_en SHALL equal (!out_valid || out_ready).
- REQ-016 MODE_DIRECT: the candidate SHALL be sel; a grant SHALL occur only when in_valid[sel] && load_en.
- REQ-017 MODE_RR: the candidate SHALL be the first channel with in_valid set, searched upward from ptr and wrapping from N_CH-1 to 0; a grant SHALL occur when any in_valid bit is set && load_en.
- REQ-018 in_ready[i] SHALL be 1 only for the granted channel in the current cycle; at most one bit SHALL be set.
- REQ-019 On a grant, the next edge SHALL load out_data with the granted channel's data, out_ch with its index, and out_valid with 1. Latency from input to output is 1 cycle.
- REQ-020 With no grant and out_ready=1, out_valid SHALL clear on the next edge. With out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold.
- REQ-021 Simultaneous drain and grant (out_valid=1, out_ready=1, grant) SHALL load the new word with no bubble; full throughput is 1 word per cycle.
- REQ-022 ptr (CH_W bits) SHALL update to (granted index + 1) mod N_CH only on a grant in MODE_RR; it SHALL wrap from N_CH-1 to 0 and hold in MODE_DIRECT.
- REQ-023 A change of mode or sel SHALL take effect in the same cycle's combinational grant decision and SHALL NOT alter the output register contents.
- REQ-024 A channel that is not granted SHALL NOT be consumed; its data must remain valid until in_ready is returned to it.
- REQ-025 With all in_valid=0, in_ready SHALL be all zero in both modes.

Reset
- REQ-026 While rst=1 at a rising edge: out_valid=0, out_data=0, out_ch=0, ptr=0.
- REQ-027 While rst=1, in_ready SHALL be all zero; a word held mid-transfer is discarded.
- REQ-028 The first grant after rst deasserts SHALL occur no earlier than the first edge with rst=0.

Structure
- REQ-029 Shared include mux_defs.vh SHALL hold MODE_DIRECT and MODE_RR; no other constants go there.
- REQ-030 The rotating priority search SHALL be a sub-module rr_pick (inputs: request vector, ptr; outputs: found flag, index), parametrised by N_CH.
- REQ-031 All sequential logic SHALL reside in rr_mux_nxw; rr_pick SHALL be purely combinational.

Verification
- REQ-032 Reset: assert rst for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
- REQ-033 Direct mode: mode=0, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2, out_valid=1.
- REQ-034 RR fairness: mode=1, in_valid=4'b1111 held, data ch0..ch3 = 8'h10..8'h13, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with no bubble.
- REQ-035 RR skip and wrap: mode=1, ptr=3, in_valid=4'b0010 -> channel 1 granted; ptr becomes 2.
- REQ-036 Backpressure: out_valid=1 with out_ready=0 for 3 cycles, in_valid=4'b0001 -> in_ready=0 and the output holds; on out_ready=1, channel 0 is granted in the same cycle.
- REQ-037 Mid-operation reset: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, ptr=0; after release, mode=1 with in_valid=4'b1111 grants channel 0 first.

Source files
------------

// File: rtl/rr_mux_nxw_pkg.sv
// Shared types for the N-channel round-robin / direct mux.
package rr_mux_nxw_pkg;
`include "mux_defs.vh"

  typedef enum logic {
    MODE_DIRECT_E = `MODE_DIRECT,
    MODE_RR_E     = `MODE_RR
  } mode_e;

endpackage

// File: rtl/mux_defs.vh
// Mode encodings shared by the mux slice.
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH
`define MODE_DIRECT 1'b0
`define MODE_RR     1'b1
`endif

// File: rtl/rr_mux_nxw_pick.sv
// Rotating-priority search: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            found,
  output logic [CH_W-1:0] idx
);

  logic [CH_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest match wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      cand = ptr + CH_W'(off);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_nxw.sv
// N-channel mux with direct or round-robin selection and a registered output stage.
module rr_mux_nxw
  import rr_mux_nxw_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [CH_W-1:0]       sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Handshake: an input word moves when in_valid[i] && in_ready[i]; the
  // output word moves when out_valid && out_ready. in_ready is one-hot or zero.

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;

  logic            rr_found;
  logic [CH_W-1:0] rr_idx;
  logic            load_en;
  logic            cand_ok;
  logic [CH_W-1:0] cand;
  logic            grant;

  rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  always_comb begin
    load_en     = !out_valid_q || out_ready;
    cand        = sel;
    cand_ok     = in_valid[sel];
    if (mode == MODE_RR_E) begin
      cand    = rr_idx;
      cand_ok = rr_found;
    end
    // Reset masks the grant so nothing is consumed while the stage is cleared.
    grant       = cand_ok && load_en && !rst;
    in_ready    = '0;
    if (grant) in_ready[cand] = 1'b1;

    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_data_d  = in_data[int'(cand)*WIDTH +: WIDTH];
      out_ch_d    = cand;
      out_valid_d = 1'b1;
      if (mode == MODE_RR_E) ptr_d = cand + CH_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_nxw.sv
// Directed plus random bench for rr_mux_nxw with a reference model and expected queue.
module tb_rr_mux_nxw;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int CH_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mode;
  logic [CH_W-1:0]       sel;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  out_valid;
  logic                  out_ready;

  rr_mux_nxw #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  logic [CH_W+WIDTH-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [CH_W-1:0]  m_ch;
  int               m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [WIDTH-1:0] d0, d1, d2, d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 4'b1111;
    mode     = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      #1 check("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_ptr", dut.ptr_q, 0);
      if (i < cycles - 1) @(negedge clk);
    end
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = '0;
    m_ptr   = 0;
    exp_q.delete();
  endtask

  // One cycle: drive, check the combinational grant, clock, check the output stage.
  task automatic step(input string tag, input logic md, input logic [CH_W-1:0] s,
                      input logic [N_CH-1:0] v, input logic ordy);
    logic             load, ok, gnt;
    int               c;
    logic [N_CH-1:0]  exp_rdy;
    logic [CH_W+WIDTH-1:0] w;
    @(negedge clk);
    rst = 1'b0; mode = md; sel = s; in_valid = v; out_ready = ordy;
    #1;
    load = !m_valid || ordy;
    ok = 1'b0; c = 0;
    if (md) begin
      for (int k = N_CH - 1; k >= 0; k--)
        if (v[(m_ptr + k) % N_CH]) begin ok = 1'b1; c = (m_ptr + k) % N_CH; end
    end else begin
      c = int'(s); ok = v[s];
    end
    gnt = ok && load;
    exp_rdy = gnt ? N_CH'(1 << c) : '0;
    check({tag, "_in_ready"}, in_ready, exp_rdy);
    if (gnt) exp_q.push_back({CH_W'(c), in_data[c*WIDTH +: WIDTH]});
    @(posedge clk);
    #1;
    if (gnt) begin
      w = exp_q.pop_front();
      m_ch = w[WIDTH +: CH_W];
      m_data = w[WIDTH-1:0];
      m_valid = 1'b1;
      if (md) m_ptr = (c + 1) % N_CH;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    check({tag, "_out_valid"}, out_valid, m_valid);
    check({tag, "_out_data"}, out_data, m_data);
    check({tag, "_out_ch"}, out_ch, m_ch);
    check({tag, "_ptr"}, dut.ptr_q, m_ptr);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = 0;

    do_reset(2);

    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    step("direct", 1'b0, 2'd2, 4'b0100, 1'b1);
    check("direct_data_A5", out_data, 8'hA5);
    check("direct_ch2", out_ch, 2);

    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int i = 0; i < 5; i++) begin
      step("rr_fair", 1'b1, 2'd0, 4'b1111, 1'b1);
      check("rr_fair_seq", out_ch, i % N_CH);
    end

    step("rr_to_ptr3", 1'b1, 2'd0, 4'b0100, 1'b1);
    check("ptr_is_3", dut.ptr_q, 3);
    step("rr_wrap", 1'b1, 2'd0, 4'b0010, 1'b1);
    check("wrap_ch1", out_ch, 1);
    check("wrap_ptr2", dut.ptr_q, 2);

    for (int i = 0; i < 3; i++) step("bp_hold", 1'b1, 2'd0, 4'b0001, 1'b0);
    check("bp_held_ch", out_ch, 1);
    step("bp_release", 1'b1, 2'd0, 4'b0001, 1'b1);
    check("bp_release_ch0", out_ch, 0);

    step("idle_direct", 1'b0, 2'd1, 4'b0000, 1'b1);
    step("idle_rr", 1'b1, 2'd1, 4'b0000, 1'b1);
    step("direct_miss", 1'b0, 2'd3, 4'b0001, 1'b1);

    step("pre_rst_load", 1'b1, 2'd0, 4'b0100, 1'b1);
    step("pre_rst_hold", 1'b1, 2'd0, 4'b0100, 1'b0);
    do_reset(1);
    step("post_rst", 1'b1, 2'd0, 4'b1111, 1'b1);
    check("post_rst_ch0", out_ch, 0);

    for (int i = 0; i < 60; i++) begin
      set_data(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
